// File: rtl/subtractor_16_seq_if.sv
// Request/result bundle for subtractor_16_seq: start/a/b/bi in, d/bo/busy/done out.
interface subtractor_16_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bi;
  logic [15:0] d;
  logic        bo;
  logic        busy;
  logic        done;

  modport master (output start, a, b, bi, input  d, bo, busy, done);
  modport slave  (input  start, a, b, bi, output d, bo, busy, done);
endinterface

// File: rtl/subtractor_16_seq.sv
// Multi-cycle 16-bit subtractor, SLICE_W bits per cycle, LSB slice first.
// Optional macro SUB16_SAT_EN: clamp d to 0x0000 when the final borrow is set.
module subtractor_16_seq #(
  parameter int SLICE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  subtractor_16_seq_if.slave  bus
);
  localparam int N  = 16 / SLICE_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state, w_next;
  logic [15:0]     r_a, r_b, r_res, r_d;
  logic            r_bw, r_bo;
  logic [CW-1:0]   r_cnt;
  logic [SLICE_W:0] w_sub;
  logic [15:0]     w_res;
  logic            w_accept, w_last;

  // DONE accepts a new start just like IDLE, so back-to-back ops have no gap
  assign w_accept = bus.start && (r_state != RUN);
  assign w_last   = (r_cnt == CW'(N - 1));

  // Operands shift right each cycle so the active slice is always at bit 0
  assign w_sub = {1'b0, r_a[SLICE_W-1:0]} - {1'b0, r_b[SLICE_W-1:0]}
               - (SLICE_W+1)'(r_bw);
  assign w_res = (r_res >> SLICE_W) | (16'(w_sub[SLICE_W-1:0]) << (16 - SLICE_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last)   w_next = DONE;
      DONE:    w_next = w_accept ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_bw  <= 1'b0;
      r_res <= '0;
      r_cnt <= '0;
      r_d   <= '0;
      r_bo  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_bw  <= bus.bi;
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> SLICE_W;
      r_b   <= r_b >> SLICE_W;
      r_bw  <= w_sub[SLICE_W];
      r_res <= w_res;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_bo <= w_sub[SLICE_W];
`ifdef SUB16_SAT_EN
        r_d  <= w_sub[SLICE_W] ? 16'h0000 : w_res;
`else
        r_d  <= w_res;
`endif
      end
    end
  end

  assign bus.d    = r_d;
  assign bus.bo   = r_bo;
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
endmodule
